// File: rtl/unary_bound_arith.sv
`default_nettype none
// ============================================================================
//  Module   : unary_bound_arith
//  Brief    : Bounds-based unary arithmetic over two LEN-bit unary streams.
//             mode 0 emits floor(A*B/LEN) ones, mode 1 emits floor((A+B)/2)
//             ones. Output bits are released as soon as running lower/upper
//             bounds make them certain, with a valid/ready output handshake.
//  Options  : `define UNARY_OVF_FLAG_EN adds a sticky 'ovf' output that flags
//             input bits offered after a stream already holds LEN bits.
//  Revision : 1.0 - initial release
// ============================================================================
module unary_bound_arith #(
  parameter int LEN = 32,
  parameter int CW  = $clog2(LEN + 1),
  parameter int PW  = 2 * CW
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic mode,
  input  logic a,
  input  logic a_valid,
  input  logic b,
  input  logic b_valid,
  output logic y,
  output logic y_valid,
  input  logic y_ready,
  output logic done
`ifdef UNARY_OVF_FLAG_EN
  ,
  output logic ovf
`endif
);

  localparam logic [CW-1:0] LEN_C = CW'(LEN);
  localparam logic [PW-1:0] LEN_P = PW'(LEN);
  localparam logic [CW-1:0] ONE_C = CW'(1);

  logic          mode_q;
  logic [CW-1:0] a_ones;
  logic [CW-1:0] a_cnt;
  logic [CW-1:0] b_ones;
  logic [CW-1:0] b_cnt;
  logic [CW-1:0] y_ones;
  logic [CW-1:0] y_cnt;

  logic [CW-1:0] a_hi;
  logic [CW-1:0] b_hi;
  logic [PW-1:0] prod_lo;
  logic [PW-1:0] prod_hi;
  logic [CW:0]   sum_lo;
  logic [CW:0]   sum_hi;
  logic [CW-1:0] y_lo;
  logic [CW-1:0] y_hi;

  logic a_take;
  logic b_take;
  logic slot;
  logic load_one;
  logic load_zero;
  logic xfer;

  // Running bounds on the final result, derived from registered counts only.
  // Unseen input bits are assumed 0 for the lower bound and 1 for the upper.
  always_comb begin
    a_hi    = a_ones + (LEN_C - a_cnt);
    b_hi    = b_ones + (LEN_C - b_cnt);
    prod_lo = PW'(a_ones) * PW'(b_ones);
    prod_hi = PW'(a_hi) * PW'(b_hi);
    sum_lo  = {1'b0, a_ones} + {1'b0, b_ones};
    sum_hi  = {1'b0, a_hi} + {1'b0, b_hi};
    if (mode_q) begin
      y_lo = CW'(sum_lo >> 1);
      y_hi = CW'(sum_hi >> 1);
    end else begin
      y_lo = CW'(prod_lo / LEN_P);
      y_hi = CW'(prod_hi / LEN_P);
    end
  end

  // Input acceptance and output slot decisions; a 1 wins over a 0.
  always_comb begin
    a_take    = a_valid && (a_cnt != LEN_C);
    b_take    = b_valid && (b_cnt != LEN_C);
    xfer      = y_valid && y_ready;
    slot      = (!y_valid || y_ready) && (y_cnt != LEN_C);
    load_one  = slot && (y_ones < y_lo);
    load_zero = slot && !load_one && ((y_cnt - y_ones) < (LEN_C - y_hi));
  end

  // Input stream counters; a bit offered alongside start opens the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      a_ones <= '0;
      a_cnt  <= '0;
      b_ones <= '0;
      b_cnt  <= '0;
    end else if (start) begin
      mode_q <= mode;
      a_cnt  <= a_valid ? ONE_C : '0;
      a_ones <= CW'(a_valid && a);
      b_cnt  <= b_valid ? ONE_C : '0;
      b_ones <= CW'(b_valid && b);
    end else begin
      if (a_take) begin
        a_cnt  <= a_cnt + ONE_C;
        a_ones <= a_ones + CW'(a);
      end
      if (b_take) begin
        b_cnt  <= b_cnt + ONE_C;
        b_ones <= b_ones + CW'(b);
      end
    end
  end

  // Output register: load a certain bit into a free slot, else hold or drain.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
      y_ones  <= '0;
      y_cnt   <= '0;
    end else if (load_one) begin
      y       <= 1'b1;
      y_valid <= 1'b1;
      y_ones  <= y_ones + ONE_C;
      y_cnt   <= y_cnt + ONE_C;
    end else if (load_zero) begin
      y       <= 1'b0;
      y_valid <= 1'b1;
      y_cnt   <= y_cnt + ONE_C;
    end else if (xfer) begin
      y_valid <= 1'b0;
    end
  end

  // Frame completion: the presented bit is the last one once y_cnt hits LEN.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      done <= 1'b0;
    end else if (xfer && (y_cnt == LEN_C)) begin
      done <= 1'b1;
    end
  end

`ifdef UNARY_OVF_FLAG_EN
  // Sticky flag for input bits offered to an already full stream.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      ovf <= 1'b0;
    end else if ((a_valid && (a_cnt == LEN_C)) || (b_valid && (b_cnt == LEN_C))) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unary_bound_arith.sv
`default_nettype none
// ============================================================================
//  Module   : tb_unary_bound_arith
//  Brief    : Directed self-checking bench for unary_bound_arith (LEN=8 and
//             LEN=7 instances sharing stimulus). Honours UNARY_OVF_FLAG_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_unary_bound_arith;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, mode, a, a_valid, b, b_valid, y_ready;
  logic y8, yv8, done8;
  logic y7, yv7, done7;
`ifdef UNARY_OVF_FLAG_EN
  logic ovf8, ovf7;
`endif

  int checks = 0;
  int errors = 0;

  unary_bound_arith #(.LEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .a(a), .a_valid(a_valid), .b(b), .b_valid(b_valid),
    .y(y8), .y_valid(yv8), .y_ready(y_ready), .done(done8)
`ifdef UNARY_OVF_FLAG_EN
    , .ovf(ovf8)
`endif
  );

  unary_bound_arith #(.LEN(7)) dut7 (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .a(a), .a_valid(a_valid), .b(b), .b_valid(b_valid),
    .y(y7), .y_valid(yv7), .y_ready(y_ready), .done(done7)
`ifdef UNARY_OVF_FLAG_EN
    , .ovf(ovf7)
`endif
  );

  // Drives one frame (start with bit 0, then bits 1..n-1) and observes output.
  task automatic run_frame(input logic [7:0] abits, input logic [7:0] bbits,
                           input int n, input logic md,
                           input int hold_lo, input int hold_hi, input bit use7,
                           output int ones, output int xfers, output bit done_seen,
                           output int unstable, output int held,
                           output logic v_after, output logic d_after);
    logic pv, pr, py, cy, cv, cd;
    logic [2:0] idx;
    ones = 0; xfers = 0; done_seen = 0; unstable = 0; held = 0;
    v_after = 1'b0; d_after = 1'b0;
    pv = 1'b0; pr = 1'b1; py = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = md; y_ready = 1'b1;
    a_valid = 1'b1; a = abits[0];
    b_valid = 1'b1; b = bbits[0];
    for (int cyc = 1; cyc < 80; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      cy = use7 ? y7 : y8;
      cv = use7 ? yv7 : yv8;
      cd = use7 ? done7 : done8;
      if (cyc == 1) begin
        v_after = cv;
        d_after = cd;
      end
      if (cd) begin
        done_seen = 1'b1;
        break;
      end
      idx = cyc[2:0];
      if (cyc < n) begin
        a_valid = 1'b1; a = abits[idx];
        b_valid = 1'b1; b = bbits[idx];
      end else begin
        a_valid = 1'b0; a = 1'b0;
        b_valid = 1'b0; b = 1'b0;
      end
      y_ready = !(cyc >= hold_lo && cyc < hold_hi);
      if (pv && !pr) begin
        held++;
        if (cv !== 1'b1 || cy !== py) unstable++;
      end
      if (cv && y_ready) begin
        xfers++;
        ones += int'(cy);
      end
      pv = cv; pr = y_ready; py = cy;
    end
    a_valid = 1'b0; b_valid = 1'b0; y_ready = 1'b1;
  endtask

  // Reset wins over start; afterwards the frame runs in multiply mode.
  task automatic test_reset();
    int ones, xf;
    bit dn;
    reset = 1'b1; start = 1'b1; mode = 1'b1; y_ready = 1'b1;
    a_valid = 1'b1; a = 1'b1; b_valid = 1'b1; b = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (yv8 !== 1'b0) begin errors++; $display("FAIL reset_y_valid: got %b expected 0", yv8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    checks++; if (y8 !== 1'b0) begin errors++; $display("FAIL reset_y: got %b expected 0", y8); end
    ones = 0; xf = 0; dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (done8) begin dn = 1; break; end
      reset = 1'b0; start = 1'b0;
      a_valid = (i < 8); a = 1'b1;
      b_valid = (i < 8); b = 1'b0;
      if (yv8 && y_ready) begin xf++; ones += int'(y8); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL reset_frame_done: got %b expected 1", dn); end
    checks++; if (xf != 8) begin errors++; $display("FAIL reset_frame_xfers: got %0d expected 8", xf); end
    checks++; if (ones != 0) begin errors++; $display("FAIL reset_frame_ones (mode_q=0): got %0d expected 0", ones); end
  endtask

  // Directed frames for both modes with hand-computed results.
  task automatic test_frames();
    logic [7:0] av [7] = '{8'hff, 8'h55, 8'hff, 8'h00, 8'hff, 8'h07, 8'hff};
    logic [7:0] bv [7] = '{8'h0f, 8'hff, 8'hff, 8'h00, 8'h00, 8'h01, 8'hff};
    logic       mv [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int         ev [7] = '{4, 4, 8, 0, 4, 2, 8};
    int ones, xf, us, hd;
    bit dn;
    logic va, da;
    for (int i = 0; i < 7; i++) begin
      run_frame(av[i], bv[i], 8, mv[i], 0, 0, 1'b0, ones, xf, dn, us, hd, va, da);
      checks++; if (da !== 1'b0) begin errors++; $display("FAIL frame%0d done_after_start: got %b expected 0", i, da); end
      checks++; if (dn !== 1'b1) begin errors++; $display("FAIL frame%0d done: got %b expected 1", i, dn); end
      checks++; if (xf != 8) begin errors++; $display("FAIL frame%0d xfers: got %0d expected 8", i, xf); end
      checks++; if (ones != ev[i]) begin errors++; $display("FAIL frame%0d ones: got %0d expected %0d", i, ones, ev[i]); end
    end
  endtask

  // A leading 0 on A alone already pins one output 0 (y_hi=7).
  task automatic test_early();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; y_ready = 1'b1;
    a_valid = 1'b1; a = 1'b0; b_valid = 1'b0; b = 1'b0;
    @(negedge clk);
    start = 1'b0; a_valid = 1'b0;
    checks++; if (yv8 !== 1'b0) begin errors++; $display("FAIL early_cycle1_valid: got %b expected 0", yv8); end
    @(negedge clk);
    checks++; if (yv8 !== 1'b1) begin errors++; $display("FAIL early_cycle2_valid: got %b expected 1", yv8); end
    checks++; if (y8 !== 1'b0) begin errors++; $display("FAIL early_cycle2_y: got %b expected 0", y8); end
    @(negedge clk);
    checks++; if (yv8 !== 1'b0) begin errors++; $display("FAIL early_after_xfer_valid: got %b expected 0", yv8); end
  endtask

  // Non-power-of-two divide: LEN=7, 7*7/7 = 7 ones.
  task automatic test_nonpow2();
    int ones, xf, us, hd;
    bit dn;
    logic va, da;
    run_frame(8'h7f, 8'h7f, 7, 1'b0, 0, 0, 1'b1, ones, xf, dn, us, hd, va, da);
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL len7_done: got %b expected 1", dn); end
    checks++; if (xf != 7) begin errors++; $display("FAIL len7_xfers: got %0d expected 7", xf); end
    checks++; if (ones != 7) begin errors++; $display("FAIL len7_ones: got %0d expected 7", ones); end
  endtask

  // y_ready low for 5 cycles mid-frame; output must hold and nothing is lost.
  task automatic test_backpressure();
    int ones, xf, us, hd;
    bit dn;
    logic va, da;
    run_frame(8'hff, 8'h00, 8, 1'b1, 4, 9, 1'b0, ones, xf, dn, us, hd, va, da);
    checks++; if (hd != 5) begin errors++; $display("FAIL bp_held_cycles: got %0d expected 5", hd); end
    checks++; if (us != 0) begin errors++; $display("FAIL bp_unstable: got %0d expected 0", us); end
    checks++; if (xf != 8) begin errors++; $display("FAIL bp_xfers: got %0d expected 8", xf); end
    checks++; if (ones != 4) begin errors++; $display("FAIL bp_ones: got %0d expected 4", ones); end
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL bp_done: got %b expected 1", dn); end
  endtask

  // Restart mid-frame in average mode; the pending bit is dropped.
  task automatic test_restart();
    int ones, xf, us, hd;
    bit dn;
    logic va, da;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; y_ready = 1'b1;
    a_valid = 1'b1; a = 1'b1; b_valid = 1'b1; b = 1'b1;
    xf = 0;
    for (int cyc = 1; cyc < 40 && xf < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      a_valid = (cyc < 8); b_valid = (cyc < 8);
      if (yv8) xf++;
    end
    checks++; if (xf != 3) begin errors++; $display("FAIL restart_setup_xfers: got %0d expected 3", xf); end
    run_frame(8'hff, 8'h00, 8, 1'b1, 0, 0, 1'b0, ones, xf, dn, us, hd, va, da);
    checks++; if (va !== 1'b0) begin errors++; $display("FAIL restart_valid_dropped: got %b expected 0", va); end
    checks++; if (da !== 1'b0) begin errors++; $display("FAIL restart_done: got %b expected 0", da); end
    checks++; if (xf != 8) begin errors++; $display("FAIL restart_xfers: got %0d expected 8", xf); end
    checks++; if (ones != 4) begin errors++; $display("FAIL restart_ones: got %0d expected 4", ones); end
  endtask

`ifdef UNARY_OVF_FLAG_EN
  // Ninth A pulse in an 8-bit frame raises ovf without disturbing the result.
  task automatic test_ovf();
    int ones;
    bit dn;
    ones = 0; dn = 0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; y_ready = 1'b1;
    a_valid = 1'b1; a = 1'b1; b_valid = 1'b1; b = 1'b1;
    for (int cyc = 1; cyc < 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 8) begin
        checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_after_8: got %b expected 0", ovf8); end
      end
      if (cyc == 9) begin
        checks++; if (ovf8 !== 1'b1) begin errors++; $display("FAIL ovf_after_9: got %b expected 1", ovf8); end
      end
      if (done8) begin dn = 1; break; end
      a_valid = (cyc < 9); a = 1'b1;
      b_valid = (cyc < 8); b = (cyc < 4);
      if (yv8 && y_ready) ones += int'(y8);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    checks++; if (dn !== 1'b1) begin errors++; $display("FAIL ovf_frame_done: got %b expected 1", dn); end
    checks++; if (ones != 4) begin errors++; $display("FAIL ovf_frame_ones: got %0d expected 4", ones); end
    checks++; if (ovf7 !== 1'b1) begin errors++; $display("FAIL ovf_len7: got %b expected 1", ovf7); end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL ovf_cleared_by_start: got %b expected 0", ovf8); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; y_ready = 1'b1;
    a = 1'b0; a_valid = 1'b0; b = 1'b0; b_valid = 1'b0;
    test_reset();
    test_frames();
    test_early();
    test_nonpow2();
    test_backpressure();
    test_restart();
`ifdef UNARY_OVF_FLAG_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/unary_bound_arith.md
Name: unary_bound_arith

Overview:
- Parametrised successor to the bounds-based unary multiplier.
- Consumes two unary bitstreams of length LEN (a, b) and emits an output unary stream of length LEN whose ones count is the scaled product (MODE=0) or the scaled average (MODE=1).
- Output bits are emitted as early as the running lower/upper bounds allow, so downstream stages can begin before the inputs finish.
- Adds exact divide-by-LEN scaling (any LEN, not only powers of two), a valid/ready output handshake, frame restart and a done flag.

Parameters:
- LEN, 32, bitstream length per frame (>=2).
- CW, $clog2(LEN+1), counter width (derived; do not override).
- PW, 2*CW, product width for bound arithmetic (derived).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; clears the frame and latches mode
- mode  input  1  0 = multiply, 1 = scaled add; sampled only on start
- a  input  1  input stream A bit
- a_valid  input  1  a is present this cycle
- b  input  1  input stream B bit
- b_valid  input  1  b is present this cycle
- y  output  1  output stream bit
- y_valid  output  1  y is presented
- y_ready  input  1  consumer accepts y this cycle
- done  output  1  high once LEN output bits have been accepted; held until start or reset

Behaviour:
- Reset is synchronous and active-high: clk and reset as named above; all counters are cleared, mode_q=0, y=0, y_valid=0, done=0.
- start clears a_ones, a_cnt, b_ones, b_cnt, y_ones and y_cnt, drops any pending output (y_valid=0) and clears done. If reset and start are asserted together, reset wins.
- An input bit offered in the same cycle as start counts toward the new frame.
- Input accept: when a_valid and a_cnt<LEN, a_cnt+=1 and a_ones+=a. When a_cnt==LEN, extra bits are ignored. The same rules apply to b. There is no input backpressure.
- Bounds are combinational on registered counts:
  - a_lo=a_ones; a_hi=a_ones+LEN-a_cnt; likewise for b.
  - MODE 0: y_lo=floor(a_lo*b_lo/LEN); y_hi=floor(a_hi*b_hi/LEN). Use the PW-bit product with true integer divide by LEN.
  - MODE 1: y_lo=floor((a_lo+b_lo)/2); y_hi=floor((a_hi+b_hi)/2).
- Emission (load slot): a slot exists when (!y_valid || y_ready) and y_cnt<LEN, where y_cnt counts generated bits. Within a slot:
  - If y_ones<y_lo: load y=1, y_valid=1, y_ones+=1, y_cnt+=1.
  - Else if (y_cnt-y_ones)<(LEN-y_hi): load y=0, y_valid=1, y_cnt+=1.
  - Else: y_valid<=0 if the previous bit was accepted; otherwise hold.
  - A 1 has priority over a 0 when both are legal.
- Latency: a bit becomes legal one cycle after the input count update; it is presented as y_valid the following edge (registered).
- Handshake: y and y_valid hold steady while y_valid && !y_ready. A bit is transferred on y_valid && y_ready.
- done rises on the edge where the LEN-th bit is transferred. No emission occurs after y_cnt==LEN.
- Invariant: the final y_ones equals the exact floor result. The emitted ones never exceed y_hi and the emitted zeros never exceed LEN-y_lo.

Optional Feature:
- Macro: UNARY_OVF_FLAG_EN.
- Defined: adds output port ovf (1 bit), a sticky flag set when a_valid or b_valid is asserted with the corresponding count ==LEN. It is cleared by start or reset; reset value 0.
- Undefined: no ovf port; extra input bits are silently dropped.

Test Plan:
- LEN=8, mode 0, a=8 ones, b=11110000, y_ready=1 -> exactly 8 transfers with 4 ones total; done=1 after the 8th transfer.
- LEN=8, mode 0, first a bit=0 (b_valid=0) -> y_hi=7, so y=0 with y_valid=1 appears 2 cycles after the a bit, before stream B starts.
- LEN=8, mode 1, a=8 ones, b=8 zeros -> 4 ones and 4 zeros emitted; LEN=7 mode 0 with a=b=7 ones -> 7 ones (checks non-power-of-two divide).
- Hold y_ready=0 for 5 cycles mid-frame -> y and y_valid stable throughout; no bits lost or duplicated; total count still 8.
- Assert start at y_cnt=3 with mode=1 -> y_valid=0 the next cycle, done=0, and the new frame produces the full 8-bit result of the average.
- With UNARY_OVF_FLAG_EN: 9 a_valid pulses in an 8-bit frame -> ovf=1 from the 9th, y result unchanged; ovf clears on start.
